sprite_palette_arbiter: RTL and testbench
=========================================

SPRITE_PALETTE_ARBITER -- requirements
Module: sprite_palette_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter IDX_W, default 4, palette index width.
REQ-003 SHALL have parameter TRANSP_IDX, default 0, index flagged as transparent.
REQ-004 SHALL have parameter FLASH_LEN, default 16, flash duration in cycles.
REQ-005 SHALL have port Clk, input, 1, system clock; one clock, all logic on rising edge.
REQ-006 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester lookup request.
REQ-008 SHALL have port req_index, input, NUM_REQ x IDX_W, per-requester palette index.
REQ-009 SHALL have port req_grant, output, NUM_REQ, one-hot acceptance, same cycle as request.
REQ-010 SHALL have port pal_index, output, IDX_W, registered index to shared palette ROM.
REQ-011 SHALL have port pal_red/pal_green/pal_blue, input, 4 each, combinational palette response.
REQ-012 SHALL have port out_valid, output, 1, result strobe.
REQ-013 SHALL have port out_id, output, clog2(NUM_REQ), requester that owns the result.
REQ-014 SHALL have port out_red/out_green/out_blue, output, 4 each, resolved colour.
REQ-015 SHALL have port out_transp, output, 1, result index equals TRANSP_IDX.
REQ-016 SHALL have ports flash_start (input, 1), flash_id (input, clog2(NUM_REQ)), flash_active (output, 1).

Function
REQ-017 SHALL grant at most one requester per cycle, round-robin, starting the search at rr_ptr.
REQ-018 SHALL set rr_ptr to (winner+1) mod NUM_REQ after a grant; it SHALL hold rr_ptr when no request is present.
REQ-019 SHALL drive req_grant combinationally; a requester SHALL hold req_valid/req_index until granted.
REQ-020 SHALL register the winner's index into pal_index and its id into stage 1 on the grant edge.
REQ-021 SHALL register the palette response into the out_* signals one cycle later; out_valid is asserted exactly 2 cycles after grant.
REQ-022 SHALL sustain one result per cycle when requests are continuous (fully pipelined, no stalls).
REQ-023 SHALL hold pal_index and out_* colour/id at last values when idle; out_valid SHALL be 0 when idle.
REQ-024 SHALL compute out_transp from the stage-1 index, aligned with out_valid.
REQ-025 SHALL drop NUM_REQ requesters with req_valid low from arbitration; the all-zero request vector yields req_grant = 0.

Reset
REQ-026 SHALL, on Reset high at a clock edge: rr_ptr=0, stage valids=0, out_valid=0, out_id=0, out_* colour=0, out_transp=0, pal_index=0, flash counter=0, flash_active=0.
REQ-027 SHALL force req_grant=0 while Reset is high; in-flight results SHALL be discarded, not emitted after reset.

Configuration
REQ-028 SHALL use macro SPRITE_PALETTE_FLASH_EN.
REQ-029 With the macro defined: flash_start loads the counter with FLASH_LEN and latches flash_id; flash_active = (counter != 0); the counter decrements each cycle; a new flash_start while active reloads the counter and flash_id.
REQ-030 With the macro defined: while flash_active and out_id equals the latched id, each colour output SHALL be 4'hF minus the palette value, evaluated on the output-stage register.
REQ-031 Without the macro: flash ports SHALL still exist but be ignored; flash_active SHALL be tied to 0, with no counter logic.

Structure
REQ-032 SHALL place NUM_REQ/IDX_W defaults, the rgb444_t struct (red, green, blue nibbles) and TRANSP_IDX in package zelda_gfx_pkg.
REQ-033 SHALL implement round-robin selection in one sub-module, rr_arbiter (inputs req vector and ptr; outputs one-hot grant and winner id).
REQ-034 SHALL keep the palette ROM external; the block only sequences access to it.

Verification
REQ-035 Single request: req_valid=4'b0010, idx 3 with the palette returning 8,B,3 -> grant 4'b0010 at cycle 0, pal_index=3 at cycle 1, out_valid with id=1 and rgb=8,B,3 at cycle 2.
REQ-036 All four requesting continuously with rr_ptr=0 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; out_id sequence 0,1,2,3,0.
REQ-037 Transparency: index 0 with the palette returning 0,7,0 -> out_transp=1; index 5 -> out_transp=0.
REQ-038 Flash (macro on): flash_start with id=2, then requester 2 at idx 1 (B,6,1) -> out 4,9,E, and flash_active falls after exactly 16 cycles; requester 0 is unaffected.
REQ-039 Reset mid-stream: assert Reset while two results are in flight -> out_valid=0 for the reset cycle and the following cycle, and the first grant after reset goes to the lowest requesting index.
REQ-040 Macro off: the REQ-038 stimulus -> colours are not inverted and flash_active stays 0.

Source files
------------

// File: rtl/zelda_gfx_pkg.sv
// ---------------------------------------------------------------------------
// zelda_gfx_pkg
// Shared graphics definitions for the sprite pipeline.
//   NUM_REQ_DEF     default number of palette requesters
//   IDX_W_DEF       default palette index width
//   TRANSP_IDX_DEF  default palette index treated as transparent
//   rgb444_t        one 12-bit colour as red/green/blue nibbles
//   rgb_invert()    per-channel 4'hF minus value (used for hit flashing)
// ---------------------------------------------------------------------------
package zelda_gfx_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int IDX_W_DEF      = 4;
  localparam int TRANSP_IDX_DEF = 0;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb444_t;

  function automatic rgb444_t rgb_invert(input rgb444_t c);
    rgb444_t r;
    r.red   = 4'hF - c.red;
    r.green = 4'hF - c.green;
    r.blue  = 4'hF - c.blue;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. The search starts at ptr and
// wraps around; the first requester found wins.
// Ports:
//   req     [N-1:0]     request vector
//   ptr     [ID_W-1:0]  first requester to consider (0..N-1)
//   grant   [N-1:0]     one-hot grant, all zero when req is all zero
//   winner  [ID_W-1:0]  index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] winner
);

  always_comb begin : search
    int   cand;
    logic found;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 0; i < N; i++) begin
      // ptr never exceeds N-1, so a plain modulo gives the wrapped position.
      cand = (int'(ptr) + i) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        winner      = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sprite_palette_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_palette_arbiter
// Shares one external palette ROM between NUM_REQ sprite requesters.
// A round-robin grant is issued combinationally; the winner's index is
// registered onto pal_index, the ROM answers combinationally, and the colour
// is registered onto out_* one cycle later (result 2 cycles after grant,
// one result per cycle sustained).
//
// Optional feature, macro SPRITE_PALETTE_FLASH_EN: a flash_start pulse makes
// results of requester flash_id come out colour-inverted for FLASH_LEN
// cycles. Without the macro the flash inputs are ignored and flash_active
// is tied low.
//
// Ports:
//   Clk, Reset                   clock, synchronous active-high reset
//   req_valid/req_index          per-requester lookup (held until granted)
//   req_grant                    one-hot grant, same cycle as request
//   pal_index                    registered index to the palette ROM
//   pal_red/green/blue           palette ROM response
//   out_valid/out_id             result strobe and owning requester
//   out_red/green/blue           resolved colour
//   out_transp                   result index equals TRANSP_IDX
//   flash_start/flash_id         start a flash on one requester
//   flash_active                 flash counter running
// ---------------------------------------------------------------------------
module sprite_palette_arbiter #(
  parameter  int NUM_REQ    = zelda_gfx_pkg::NUM_REQ_DEF,
  parameter  int IDX_W      = zelda_gfx_pkg::IDX_W_DEF,
  parameter  int TRANSP_IDX = zelda_gfx_pkg::TRANSP_IDX_DEF,
  parameter  int FLASH_LEN  = 16,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]   req_index,
  output logic [NUM_REQ-1:0]              req_grant,
  output logic [IDX_W-1:0]                pal_index,
  input  logic [3:0]                      pal_red,
  input  logic [3:0]                      pal_green,
  input  logic [3:0]                      pal_blue,
  output logic                            out_valid,
  output logic [ID_W-1:0]                 out_id,
  output logic [3:0]                      out_red,
  output logic [3:0]                      out_green,
  output logic [3:0]                      out_blue,
  output logic                            out_transp,
  input  logic                            flash_start,
  input  logic [ID_W-1:0]                 flash_id,
  output logic                            flash_active
);

  import zelda_gfx_pkg::*;

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_winner;
  logic               grant_any;

  logic               s1_valid;
  logic [ID_W-1:0]    s1_id;

  rgb444_t            pal_rgb;
  rgb444_t            out_rgb_d;
  rgb444_t            out_rgb_q;
  logic               flash_hit;

  // ---------------------------------------------------------------- arbiter
  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .grant  (arb_grant),
    .winner (arb_winner)
  );

  // Nothing is accepted during reset, so no lookup can slip into the
  // pipeline while it is being flushed.
  assign req_grant = Reset ? '0 : arb_grant;
  assign grant_any = |req_grant;

  // ---------------------------------------------------------------- stage 1
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the values from before the clock edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr    <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      pal_index <= '0;
    end else begin
      s1_valid <= grant_any;
      if (grant_any) begin
        rr_ptr    <= (arb_winner == ID_W'(NUM_REQ - 1)) ? '0
                                                        : arb_winner + ID_W'(1);
        s1_id     <= arb_winner;
        pal_index <= req_index[arb_winner];
      end
    end
  end

  // ---------------------------------------------------------------- flash
`ifdef SPRITE_PALETTE_FLASH_EN
  localparam int FCNT_W = $clog2(FLASH_LEN + 1);

  logic [FCNT_W-1:0] flash_cnt;
  logic [ID_W-1:0]   flash_tgt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      flash_cnt <= '0;
      flash_tgt <= '0;
    end else if (flash_start) begin
      flash_cnt <= FCNT_W'(FLASH_LEN);
      flash_tgt <= flash_id;
    end else if (flash_cnt != '0) begin
      flash_cnt <= flash_cnt - FCNT_W'(1);
    end
  end

  assign flash_active = (flash_cnt != '0);
  // s1_id is the value out_id takes at the edge that captures this colour,
  // so the comparison is made against the result's future owner.
  assign flash_hit    = flash_active && (flash_tgt == s1_id);
`else
  logic unused_flash;
  assign unused_flash = ^{flash_start, flash_id};
  assign flash_active = 1'b0;
  assign flash_hit    = 1'b0;
`endif

  // ---------------------------------------------------------------- stage 2
  assign pal_rgb   = '{red: pal_red, green: pal_green, blue: pal_blue};
  assign out_rgb_d = flash_hit ? rgb_invert(pal_rgb) : pal_rgb;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid  <= 1'b0;
      out_id     <= '0;
      out_rgb_q  <= '0;
      out_transp <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      // Colour, id and transparency hold their last values while idle.
      if (s1_valid) begin
        out_id     <= s1_id;
        out_rgb_q  <= out_rgb_d;
        out_transp <= (pal_index == IDX_W'(TRANSP_IDX));
      end
    end
  end

  assign out_red   = out_rgb_q.red;
  assign out_green = out_rgb_q.green;
  assign out_blue  = out_rgb_q.blue;

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_palette_arbiter
// Scoreboard bench. The stimulus process keeps a model of the pending
// requesters and the round-robin pointer, predicts the grant each cycle and
// pushes the expected result (colour from the bench's palette table, due two
// cycles after grant) into a queue. A negedge monitor pops and compares
// whenever a result is due and checks that outputs stay quiet/held otherwise.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sprite_palette_arbiter;

  localparam int N    = 4;
  localparam int IW   = 4;
  localparam int IDW  = 2;
  localparam int FL   = 16;
  localparam int MAXC = 8192;
`ifdef SPRITE_PALETTE_FLASH_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  logic                    Clk = 1'b0;
  logic                    Reset;
  logic [N-1:0]            req_valid;
  logic [N-1:0][IW-1:0]    req_index;
  logic [N-1:0]            req_grant;
  logic [IW-1:0]           pal_index;
  logic [3:0]              pal_red, pal_green, pal_blue;
  logic                    out_valid;
  logic [IDW-1:0]          out_id;
  logic [3:0]              out_red, out_green, out_blue;
  logic                    out_transp;
  logic                    flash_start;
  logic [IDW-1:0]          flash_id;
  logic                    flash_active;

  sprite_palette_arbiter #(
    .NUM_REQ(N), .IDX_W(IW), .TRANSP_IDX(0), .FLASH_LEN(FL)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_index(req_index), .req_grant(req_grant),
    .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .out_valid(out_valid), .out_id(out_id),
    .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
    .out_transp(out_transp),
    .flash_start(flash_start), .flash_id(flash_id), .flash_active(flash_active)
  );

  always #5 Clk = ~Clk;

  // External palette ROM model.
  logic [11:0] pal_rom [16];
  logic [11:0] pal_word;
  assign pal_word  = pal_rom[pal_index];
  assign pal_red   = pal_word[11:8];
  assign pal_green = pal_word[7:4];
  assign pal_blue  = pal_word[3:0];

  // ------------------------------------------------------------ bookkeeping
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
    end
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // ------------------------------------------------------------ model state
  typedef struct {
    int         due;
    int         id;
    logic [3:0] r, g, b;
    bit         t;
  } exp_t;

  exp_t        sbq[$];
  bit          pend [N];
  logic [IW-1:0] pidx [N];
  int          ptr      = 0;
  int          last_rst = -100;
  int          fhist [MAXC];
  bit          mon_en   = 1'b0;

  // Is a flash running during cycle c, and on whom? A flash_start seen in
  // cycle s covers cycles s+1 .. s+FL; the latest start wins; a reset in
  // cycle r cancels every start up to and including r.
  function automatic bit flash_on(input int c, output int id);
    id = -1;
    for (int s = c - 1; s >= c - FL; s--) begin
      if (s < 0 || s <= last_rst) return 1'b0;
      if (fhist[s] >= 0) begin
        id = fhist[s];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One clock cycle: drive requests, predict/check grant and flash, push the
  // expected result, then move to 1 ns after the next rising edge.
  task automatic tick();
    int         w;
    int         fid;
    bit         fon;
    logic [N-1:0] g_exp;
    exp_t       e;
    logic [11:0] word;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_index[i] = pidx[i];
    end
    #3;
    fhist[cyc] = (flash_start && !Reset) ? int'(flash_id) : -1;
    fon = flash_on(cyc, fid);
    check("flash_active", flash_active, FLASH_EN && fon);

    w = -1;
    if (!Reset) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
      end
    end
    g_exp = (w >= 0) ? (N'(1) << w) : '0;
    check("req_grant", req_grant, g_exp);

    if (w >= 0) begin
      word  = pal_rom[pidx[w]];
      e.due = cyc + 2;
      e.id  = w;
      e.r   = word[11:8];
      e.g   = word[7:4];
      e.b   = word[3:0];
      e.t   = (pidx[w] == 0);
      fon   = flash_on(cyc + 1, fid);
      if (FLASH_EN && fon && fid == w) begin
        e.r = 4'hF - e.r;
        e.g = 4'hF - e.g;
        e.b = 4'hF - e.b;
      end
      sbq.push_back(e);
      pend[w] = 1'b0;
      ptr     = (w + 1) % N;
    end

    if (Reset) begin
      while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
      ptr      = 0;
      last_rst = cyc;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic refill_all();
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        pend[i] = 1'b1;
        pidx[i] = IW'($urandom_range(0, 15));
      end
    end
  endtask

  // ------------------------------------------------------------ monitor
  logic [IDW-1:0] last_id = '0;
  logic [11:0]    last_rgb = '0;
  logic           last_t = 1'b0;

  initial forever begin
    exp_t e;
    @(negedge Clk);
    if (mon_en) begin
      if (cyc == last_rst + 1) begin
        check("reset out_valid", out_valid, 0);
        check("reset out_id", out_id, 0);
        check("reset out_rgb", {out_red, out_green, out_blue}, 0);
        check("reset out_transp", out_transp, 0);
        check("reset pal_index", pal_index, 0);
        last_id  = '0;
        last_rgb = '0;
        last_t   = 1'b0;
      end
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        check("result missing", e.due, cyc);
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        check("out_valid", out_valid, 1);
        check("out_id", out_id, e.id);
        check("out_rgb", {out_red, out_green, out_blue}, {e.r, e.g, e.b});
        check("out_transp", out_transp, e.t);
        last_id  = out_id;
        last_rgb = {out_red, out_green, out_blue};
        last_t   = out_transp;
      end else begin
        check("out_valid idle", out_valid, 0);
        check("idle hold", {out_id, out_red, out_green, out_blue, out_transp},
              {last_id, last_rgb, last_t});
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    for (int i = 0; i < 16; i++) pal_rom[i] = 12'($urandom);
    pal_rom[3] = 12'h8B3;
    pal_rom[0] = 12'h070;
    pal_rom[1] = 12'hB61;
    pal_rom[5] = 12'h5A5;
    for (int i = 0; i < MAXC; i++) fhist[i] = -1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pidx[i] = '0;
    end
    Reset       = 1'b1;
    flash_start = 1'b0;
    flash_id    = '0;
    req_valid   = '0;
    req_index   = '0;

    @(posedge Clk);
    #1;
    tick();
    tick();
    Reset  = 1'b0;
    mon_en = 1'b1;

    // Single request: requester 1, index 3 -> 8,B,3 two cycles later.
    pend[1] = 1'b1;
    pidx[1] = 3;
    repeat (4) tick();

    // Pointer back to 0, then all four continuously.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (8) begin
      refill_all();
      tick();
    end
    repeat (6) tick();

    // Transparency: index 0 then index 5.
    pend[0] = 1'b1;
    pidx[0] = 0;
    tick();
    pend[0] = 1'b1;
    pidx[0] = 5;
    tick();
    repeat (3) tick();

    // Flash on requester 2; requester 0 uses the same colour.
    flash_start = 1'b1;
    flash_id    = 2;
    tick();
    flash_start = 1'b0;
    pend[2] = 1'b1;
    pidx[2] = 1;
    pend[0] = 1'b1;
    pidx[0] = 1;
    repeat (20) tick();

    // Reset with results in flight, then requesters 2 and 3 compete.
    repeat (3) begin
      refill_all();
      tick();
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    pend[3] = 1'b1;
    pidx[3] = 7;
    pend[2] = 1'b1;
    pidx[2] = 9;
    repeat (5) tick();

    // Randomised traffic with occasional flashes and resets.
    repeat (2000) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 45) begin
          pend[i] = 1'b1;
          pidx[i] = IW'($urandom_range(0, 15));
        end
      end
      flash_start = ($urandom_range(0, 99) < 3);
      flash_id    = IDW'($urandom_range(0, N - 1));
      Reset       = ($urandom_range(0, 299) == 0);
      tick();
    end
    Reset       = 1'b0;
    flash_start = 1'b0;
    repeat (12) tick();
    check("scoreboard drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
